// File: rtl/vector_packer_if.sv
// ---------------------------------------------------------------------------
// vector_packer_if
// Bundles the element input stream and the packed-vector output stream of
// vector_packer.
//   in_data/in_valid/in_last  : element stream into the packer
//   in_ready                  : packer can take an element this cycle
//   out_vec/out_count/out_valid: packed vector, its real element count, valid
//   out_ready                 : downstream takes the vector this cycle
// Modports:
//   slave  - the packer's view
//   master - the view of the block that drives elements and consumes vectors
// ---------------------------------------------------------------------------
interface vector_packer_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CW         = $clog2(N + 1)
);
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] out_vec;
    logic [CW-1:0]           out_count;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_vec, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_vec, out_count, out_valid
    );
endinterface

// File: rtl/vector_packer.sv
// ---------------------------------------------------------------------------
// vector_packer
// Collects DATA_WIDTH-bit elements, one per input handshake, into a packed
// N*DATA_WIDTH vector. Element 0 lands in the most-significant slot. A frame
// ended early by in_last is zero-padded. The finished vector is held under a
// valid/ready handshake; while it is held, a new element may be taken in the
// same cycle the vector is consumed, giving one element per cycle sustained.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - vector_packer_if.slave (element stream in, vector stream out)
// ---------------------------------------------------------------------------
module vector_packer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    vector_packer_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int VW = N * DATA_WIDTH;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [VW-1:0] vec_q,   vec_d;
    logic [CW-1:0] count_q, count_d;

    logic in_ready;
    logic in_acc;
    logic out_acc;

    // While a vector is held, in_ready follows out_ready so the slot freed by
    // the consumer can be refilled in the same cycle.
    assign in_ready = !rst && ((state_q == FILL) || bus.out_ready);
    assign in_acc   = bus.in_valid && in_ready;
    assign out_acc  = (state_q == HOLD) && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_vec   = vec_q;
    assign bus.out_count = count_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        count_d = count_q;

        if (state_q == FILL) begin
            if (in_acc) begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) begin
                        vec_d[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                    end
                end
                count_d = CW'(idx_q) + CW'(1);
                if ((idx_q == IW'(N - 1)) || bus.in_last) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end else if (out_acc) begin
            vec_d = '0;
            idx_d = '0;
            if (in_acc) begin
                // Consume and restart in one cycle: the new element opens
                // the next vector in slot 0.
                vec_d[VW-1 -: DATA_WIDTH] = bus.in_data;
                count_d = CW'(1);
                if (bus.in_last || (N == 1)) begin
                    state_d = HOLD;
                end else begin
                    state_d = FILL;
                    idx_d   = IW'(1);
                end
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            vec_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            count_q <= count_d;
        end
    end
endmodule
